// File: rtl/uart_pkg.sv
// Shared UART frame constants and the dump controller state encoding.
package uart_pkg;

  localparam int   CLKS_PER_BIT_DEF = 5208;
  localparam logic UART_START       = 1'b0;
  localparam logic UART_STOP        = 1'b1;
  localparam int   DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_FIN
  } dump_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_phase_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. Loads on valid&ready; tx is a flop.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       bit_tick,
  output logic       last_bit
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_phase_t     phase;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  assign ready    = (phase == TX_IDLE);
  assign bit_tick = (phase != TX_IDLE) && (baud_cnt == BAUD_LAST);
  assign last_bit = (bit_idx == 3'(DATA_BITS - 1));

  // sh always holds the next data bit in sh[0]; tx is updated on each bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      tx       <= UART_STOP;
    end else if (phase == TX_IDLE) begin
      if (valid) begin
        phase    <= TX_START;
        baud_cnt <= '0;
        bit_idx  <= '0;
        sh       <= data;
        tx       <= UART_START;
      end
    end else if (!bit_tick) begin
      baud_cnt <= baud_cnt + CW'(1);
    end else begin
      baud_cnt <= '0;
      unique case (phase)
        TX_START: begin
          phase <= TX_DATA;
          tx    <= sh[0];
          sh    <= {1'b0, sh[7:1]};
        end
        TX_DATA: begin
          if (last_bit) begin
            phase <= TX_STOP;
            tx    <= UART_STOP;
          end else begin
            tx      <= sh[0];
            sh      <= {1'b0, sh[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        TX_STOP:  phase <= TX_IDLE;
        default:  phase <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ram2uart_dump.sv
// Dumps data RAM bytes 0..DEPTH-1 over UART after the processor halts.
//  state   | meaning
//  IDLE    | waiting for a rising edge on EndOperations
//  RD_REQ  | RAM read strobe for the current address
//  RD_WAIT | RAM data valid, handed to the serializer
//  START   | start bit on tx
//  DATA    | eight data bits on tx
//  STOP    | stop bit; then next address or finish
//  FIN     | dump complete, raise done
module ram2uart_dump
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EndOperations,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  // one extra address bit so a full 2**ADDR_W dump cannot wrap
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  dump_state_t     state, state_next;
  logic            eo_q;
  logic            start;
  logic [ADDR_W:0] addr, addr_next;
  logic            ser_valid, ser_ready, bit_tick, last_bit;

  assign start     = EndOperations & ~eo_q;
  assign ser_valid = (state == ST_RD_WAIT);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (ser_valid),
    .data    (ram_rdata),
    .ready   (ser_ready),
    .tx      (tx),
    .bit_tick(bit_tick),
    .last_bit(last_bit)
  );

  always_comb begin
    state_next = state;
    addr_next  = addr;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RD_REQ;
          addr_next  = '0;
        end
      end
      ST_RD_REQ:  state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (ser_ready) state_next = ST_START;
      ST_START:   if (bit_tick) state_next = ST_DATA;
      ST_DATA:    if (bit_tick && last_bit) state_next = ST_STOP;
      ST_STOP: begin
        if (bit_tick) begin
          if (addr == LAST_ADDR) begin
            state_next = ST_FIN;
          end else begin
            addr_next  = addr + (ADDR_W + 1)'(1);
            state_next = ST_RD_REQ;
          end
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      eo_q  <= 1'b0;
      addr  <= '0;
    end else begin
      state <= state_next;
      eo_q  <= EndOperations;
      addr  <= addr_next;
    end
  end

  // outputs are decoded from the next state so they line up with it as flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ram_rd_en <= (state_next == ST_RD_REQ);
      if (state_next == ST_RD_REQ) ram_addr <= addr_next[ADDR_W-1:0];
      busy <= (state_next != ST_IDLE);
      if (state == ST_FIN) done <= 1'b1;
      else if (state == ST_IDLE && start) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram2uart_dump.sv
// Bench for ram2uart_dump: three instances, per-cycle timeline model plus pinned literals.
module tb_ram2uart_dump;

  localparam int ND = 3;
  localparam int CP [ND] = '{4, 1, 2};
  localparam int DP [ND] = '{4, 1, 4};
  localparam logic [9:0] FR1 [4] = '{10'b1010101010, 10'b1101000110,
                                     10'b1000000000, 10'b1111111110};
  localparam logic [9:0] SEQ5 = 10'b1100000010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ND-1:0] eo_v;
  logic [ND-1:0] tx_v, busy_v, done_v, rd_v;
  logic [7:0] addr_a, addr_b;
  logic [1:0] addr_c;
  logic [7:0] rdata_a, rdata_b, rdata_c;
  logic [7:0] mem [ND][4];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int lit [int];
  int addr_seen [4];
  bit m_act [ND];
  int m_n [ND];
  logic m_eop [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram2uart_dump #(.CLKS_PER_BIT(4), .ADDR_W(8), .DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .EndOperations(eo_v[0]), .ram_rd_en(rd_v[0]),
    .ram_addr(addr_a), .ram_rdata(rdata_a), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  ram2uart_dump #(.CLKS_PER_BIT(1), .ADDR_W(8), .DEPTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .EndOperations(eo_v[1]), .ram_rd_en(rd_v[1]),
    .ram_addr(addr_b), .ram_rdata(rdata_b), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  ram2uart_dump #(.CLKS_PER_BIT(2), .ADDR_W(2), .DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .EndOperations(eo_v[2]), .ram_rd_en(rd_v[2]),
    .ram_addr(addr_c), .ram_rdata(rdata_c), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // synchronous RAMs, one cycle read latency
  always @(posedge clk) if (rd_v[0]) rdata_a <= mem[0][addr_a[1:0]];
  always @(posedge clk) if (rd_v[1]) rdata_b <= mem[1][addr_b[1:0]];
  always @(posedge clk) if (rd_v[2]) rdata_c <= mem[2][addr_c];

  function automatic int cur_addr(input int i);
    case (i)
      0: return int'(addr_a);
      1: return int'(addr_b);
      default: return int'(addr_c);
    endcase
  endfunction

  function automatic int lkey(input int c, input int d, input int k);
    return (c * ND + d) * 4 + k;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h exp=%0h", name, d, cyc, got, expv);
    end
  endtask

  // Model: a dump started in cycle N is a fixed timeline. Each byte k occupies
  // P = 10*C+2 cycles from N+1+k*P: read strobe, wait, then the 10-bit frame.
  always @(negedge clk) begin : cmp
    int t, p, k, o, bp, e_addr;
    logic [7:0] byt;
    logic e_tx, e_rd, e_busy, e_done;
    for (int i = 0; i < ND; i++) begin
      if (!rst_n) begin
        chk("rst_tx", i, tx_v[i], 1);
        chk("rst_busy", i, busy_v[i], 0);
        chk("rst_done", i, done_v[i], 0);
        chk("rst_rd_en", i, rd_v[i], 0);
        chk("rst_addr", i, cur_addr(i), 0);
        m_act[i] = 1'b0;
        m_eop[i] = 1'b0;
      end else begin
        p = 10 * CP[i] + 2;
        t = cyc - m_n[i];
        e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_addr = 0;
        if (m_act[i]) begin
          e_busy = (t >= 1) && (t <= DP[i] * p + 1);
          e_done = (t >= DP[i] * p + 2);
          if (t >= 1 && t <= DP[i] * p) begin
            k = (t - 1) / p;
            o = (t - 1) % p;
            if (o == 0) begin
              e_rd = 1'b1;
              e_addr = k;
            end else if (o >= 2) begin
              bp = (o - 2) / CP[i];
              byt = mem[i][k];
              if (bp == 0) e_tx = 1'b0;
              else if (bp <= 8) e_tx = byt[bp-1];
            end
          end
        end
        chk("tx", i, tx_v[i], e_tx);
        chk("busy", i, busy_v[i], e_busy);
        chk("done", i, done_v[i], e_done);
        chk("rd_en", i, rd_v[i], e_rd);
        if (e_rd) chk("ram_addr", i, cur_addr(i), e_addr);
        if (i == 2 && rd_v[2]) addr_seen[addr_c]++;
        if (lit.exists(lkey(cyc, i, 0))) chk("lit_tx", i, tx_v[i], lit[lkey(cyc, i, 0)]);
        if (lit.exists(lkey(cyc, i, 1))) chk("lit_done", i, done_v[i], lit[lkey(cyc, i, 1)]);
        if (lit.exists(lkey(cyc, i, 2))) chk("lit_busy", i, busy_v[i], lit[lkey(cyc, i, 2)]);
        if (lit.exists(lkey(cyc, i, 3)))
          for (int a = 0; a < 4; a++) chk("addr_reads", i, addr_seen[a], lit[lkey(cyc, i, 3)]);
        if (eo_v[i] && !m_eop[i] && !(m_act[i] && t <= DP[i] * p + 1)) begin
          m_act[i] = 1'b1;
          m_n[i] = cyc;
        end
        m_eop[i] = eo_v[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int d, input int w);
    eo_v[d] = 1'b1;
    tick(w);
    eo_v[d] = 1'b0;
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, n2, d;
    eo_v = '0;
    for (int i = 0; i < ND; i++)
      for (int k = 0; k < 4; k++) mem[i][k] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // level held high: one dump, literal frames and done timing
    mem[0] = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    n = cyc;
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 10; b++) lit[lkey(n + 3 + k * 42 + b * 4 + 1, 0, 0)] = int'(FR1[k][b]);
    lit[lkey(n + 169, 0, 1)] = 0;
    lit[lkey(n + 169, 0, 2)] = 1;
    lit[lkey(n + 170, 0, 1)] = 1;
    lit[lkey(n + 170, 0, 2)] = 0;
    eo_v[0] = 1'b1;
    goto(n + 180);
    eo_v[0] = 1'b0;
    tick(3);

    // single-cycle pulse
    n = cyc;
    lit[lkey(n + 170, 0, 1)] = 1;
    pulse(0, 1);
    goto(n + 180);

    // edge while busy is ignored; edge after done restarts
    for (int k = 0; k < 4; k++) mem[0][k] = 8'($urandom);
    n = cyc;
    pulse(0, $urandom_range(1, 5));
    goto(n + $urandom_range(20, 150));
    pulse(0, 2);
    goto(n + 172);
    n2 = cyc;
    lit[lkey(n2, 0, 1)] = 1;
    lit[lkey(n2 + 1, 0, 1)] = 0;
    pulse(0, 1);
    goto(n2 + 180);

    // asynchronous reset mid-frame, during a zero data bit of byte 1
    mem[0] = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    n = cyc;
    lit[lkey(n + 57, 0, 0)] = 0;
    pulse(0, 1);
    goto(n + 58);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(300);

    // one cycle per bit, single byte
    mem[1][0] = 8'h81;
    n = cyc;
    for (int j = 0; j < 10; j++) lit[lkey(n + 3 + j, 1, 0)] = int'(SEQ5[j]);
    pulse(1, 1);
    goto(n + 20);
    repeat (5) begin
      mem[1][0] = 8'($urandom);
      n = cyc;
      pulse(1, $urandom_range(1, 4));
      goto(n + 16 + $urandom_range(0, 5));
    end

    // full 2-bit address space: each address read exactly once
    for (int k = 0; k < 4; k++) mem[2][k] = 8'($urandom);
    n = cyc;
    lit[lkey(n + 95, 2, 3)] = 1;
    pulse(2, 1);
    goto(n + 100);

    // randomized dumps across all instances
    repeat (8) begin
      d = $urandom_range(0, ND - 1);
      for (int k = 0; k < 4; k++) mem[d][k] = 8'($urandom);
      n = cyc;
      pulse(d, $urandom_range(1, 30));
      goto(n + DP[d] * (10 * CP[d] + 2) + 5 + $urandom_range(0, 10));
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
